// File: rtl/tl_ul_chk_pkg.sv
// Shared opcode constants, error codes and bit-vector helpers for the TL-UL channel checker.
package tl_ul_chk_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int NUM_ERR     = 8;
  localparam int MAX_ENTRIES = 32;

  typedef enum logic [3:0] {
    ERR_NONE       = 4'd0,
    ERR_A_STABLE   = 4'd1,
    ERR_A_ILLEGAL  = 4'd2,
    ERR_DUP_SOURCE = 4'd3,
    ERR_OVERFLOW   = 4'd4,
    ERR_D_UNMATCH  = 4'd5,
    ERR_D_MISMATCH = 4'd6,
    ERR_D_STABLE   = 4'd7,
    ERR_TIMEOUT    = 4'd8
  } err_code_e;

  // Isolates the lowest set bit; used for lowest-free allocation and CAM hit selection.
  function automatic logic [MAX_ENTRIES-1:0] lowest_onehot(input logic [MAX_ENTRIES-1:0] v);
    return v & (~v + MAX_ENTRIES'(1));
  endfunction

  // Bit i of the vector stands for code i+1; the smallest code wins.
  function automatic logic [3:0] lowest_code(input logic [NUM_ERR-1:0] v);
    logic [3:0] code;
    code = ERR_NONE;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (v[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/tl_ul_chk_table.sv
// In-flight request table: source-ID CAM with allocate, lookup/retire, per-entry age and timeout.
module tl_ul_chk_table
  import tl_ul_chk_pkg::*;
#(
  parameter int SOURCE_W = 10,
  parameter int SIZE_W   = 2,
  parameter int ENTRIES  = 8,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                d_fire,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic                alloc_en,
  input  logic [SIZE_W-1:0]   alloc_size,
  input  logic                alloc_expect_data,
  output logic                d_hit,
  output logic [SIZE_W-1:0]   hit_size,
  output logic                hit_expect_data,
  output logic                a_dup,
  output logic                full,
  output logic                timeout_any,
  output logic [CNT_W-1:0]    occupancy
);

  localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_TRIP = AGE_W'(TIMEOUT - 1);

  typedef struct packed {
    logic                valid;
    logic [SOURCE_W-1:0] source;
    logic [SIZE_W-1:0]   size;
    logic                expect_data;
    logic [AGE_W-1:0]    age;
  } entry_t;

  entry_t [ENTRIES-1:0] ent_q, ent_d;
  logic   [CNT_W-1:0]   count_q, count_d;

  logic [ENTRIES-1:0]     match, retire, live_after, alloc_vec, tmo_vec;
  logic [MAX_ENTRIES-1:0] hit_oh, free_oh;

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = ent_q[i].valid && (ent_q[i].source == d_source);
    end
    hit_oh          = lowest_onehot(MAX_ENTRIES'(match));
    d_hit           = |match;
    hit_size        = '0;
    hit_expect_data = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_oh[i]) begin
        hit_size        = ent_q[i].size;
        hit_expect_data = ent_q[i].expect_data;
      end
    end
    retire = d_fire ? hit_oh[ENTRIES-1:0] : '0;

    // A-side checks see the table as it stands after this cycle's D retire.
    live_after = '0;
    a_dup      = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      live_after[i] = ent_q[i].valid && !retire[i];
      if (live_after[i] && (ent_q[i].source == a_source)) a_dup = 1'b1;
    end
    full      = &live_after;
    free_oh   = lowest_onehot(MAX_ENTRIES'(~live_after));
    alloc_vec = alloc_en ? free_oh[ENTRIES-1:0] : '0;

    // An entry answered this cycle was answered in time.
    tmo_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      tmo_vec[i] = (TIMEOUT > 0) && ent_q[i].valid && !retire[i] && (ent_q[i].age == AGE_TRIP);
    end
    timeout_any = |tmo_vec;
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_q[i].valid && (ent_q[i].age != AGE_MAX)) begin
        ent_d[i].age = ent_q[i].age + AGE_W'(1);
      end
      if (retire[i]) ent_d[i].valid = 1'b0;
      if (alloc_vec[i]) begin
        ent_d[i].valid       = 1'b1;
        ent_d[i].source      = a_source;
        ent_d[i].size        = alloc_size;
        ent_d[i].expect_data = alloc_expect_data;
        ent_d[i].age         = '0;
      end
    end
    count_d = count_q - CNT_W'(|retire) + CNT_W'(|alloc_vec);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign occupancy = count_q;

endmodule

// File: rtl/tl_ul_channel_checker.sv
// Passive TL-UL A/D channel checker: stability, legality, source matching and timeout,
// reported as a registered error pulse/code plus a sticky per-code bitmask.
module tl_ul_channel_checker
  import tl_ul_chk_pkg::*;
#(
  parameter int SOURCE_W     = 10,
  parameter int ADDR_W       = 15,
  parameter int SIZE_W       = 2,
  parameter int BEAT_BYTES   = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int TIMEOUT      = 1024,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [SIZE_W-1:0]     a_size,
  input  logic [SOURCE_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [BEAT_BYTES-1:0] a_mask,
  input  logic                  a_corrupt,
  input  logic                  d_valid,
  input  logic                  d_ready,
  input  logic [2:0]            d_opcode,
  input  logic [SIZE_W-1:0]     d_size,
  input  logic [SOURCE_W-1:0]   d_source,
  input  logic                  d_denied,
  input  logic                  d_corrupt,
  output logic                  err_pulse,
  output logic [3:0]            err_code,
  output logic [NUM_ERR-1:0]    err_sticky,
  output logic [CNT_W-1:0]      inflight
);

  localparam int LOG_BEAT = $clog2(BEAT_BYTES);

  typedef struct packed {
    logic [2:0]            opcode;
    logic [2:0]            param;
    logic [SIZE_W-1:0]     size;
    logic [SOURCE_W-1:0]   source;
    logic [ADDR_W-1:0]     address;
    logic [BEAT_BYTES-1:0] mask;
    logic                  corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
  } d_beat_t;

  logic    a_fire, d_fire;
  a_beat_t a_cur, a_snap_q, a_snap_d;
  d_beat_t d_cur, d_snap_q, d_snap_d;
  logic    a_hold_q, a_hold_d, d_hold_q, d_hold_d;
  logic    a_stab_err, d_stab_err;

  logic                  is_get, is_put_full, is_put_partial;
  logic [BEAT_BYTES-1:0] lane_mask;
  logic                  bad_op, misaligned, too_big, mask_bad, a_illegal;

  logic              d_hit, hit_expect_data, a_dup, tbl_full, timeout_any, alloc_en, d_mismatch;
  logic [SIZE_W-1:0] hit_size;

  logic [NUM_ERR-1:0] err_vec;
  logic               err_pulse_q, err_pulse_d;
  logic [3:0]         err_code_q, err_code_d;
  logic [NUM_ERR-1:0] err_sticky_q, err_sticky_d;

  assign a_fire = a_valid && a_ready;
  assign d_fire = d_valid && d_ready;
  assign a_cur  = '{a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt};
  assign d_cur  = '{d_opcode, d_size, d_source, d_denied, d_corrupt};

  // A stalled beat must be presented again unchanged on the following cycle.
  always_comb begin
    a_hold_d   = a_valid && !a_ready;
    d_hold_d   = d_valid && !d_ready;
    a_snap_d   = a_cur;
    d_snap_d   = d_cur;
    a_stab_err = a_hold_q && (!a_valid || (a_cur != a_snap_q));
    d_stab_err = d_hold_q && (!d_valid || (d_cur != d_snap_q));
  end

  always_comb begin
    is_get         = (a_opcode == OP_GET);
    is_put_full    = (a_opcode == OP_PUT_FULL);
    is_put_partial = (a_opcode == OP_PUT_PARTIAL);
    bad_op         = !(is_get || is_put_full || is_put_partial);
    too_big        = 32'(a_size) > LOG_BEAT;
    misaligned     = (a_address & ((ADDR_W'(1) << a_size) - ADDR_W'(1))) != '0;
    // A lane is enabled when it sits in the same 2^size block of the beat as the address.
    lane_mask = '0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      lane_mask[b] = ((ADDR_W'(b) ^ (a_address & ADDR_W'(BEAT_BYTES - 1))) >> a_size) == '0;
    end
    mask_bad  = ((is_get || is_put_full) && (a_mask != lane_mask))
             || (is_put_partial && ((a_mask & ~lane_mask) != '0));
    a_illegal = bad_op || (a_param != 3'd0) || misaligned || too_big || mask_bad
             || (is_get && a_corrupt);
    alloc_en  = a_fire && !a_illegal && !a_dup && !tbl_full;
  end

  tl_ul_chk_table #(
    .SOURCE_W (SOURCE_W),
    .SIZE_W   (SIZE_W),
    .ENTRIES  (MAX_INFLIGHT),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) u_table (
    .clock             (clock),
    .reset             (reset),
    .d_fire            (d_fire),
    .d_source          (d_source),
    .a_source          (a_source),
    .alloc_en          (alloc_en),
    .alloc_size        (a_size),
    .alloc_expect_data (is_get),
    .d_hit             (d_hit),
    .hit_size          (hit_size),
    .hit_expect_data   (hit_expect_data),
    .a_dup             (a_dup),
    .full              (tbl_full),
    .timeout_any       (timeout_any),
    .occupancy         (inflight)
  );

  always_comb begin
    d_mismatch = (d_opcode != (hit_expect_data ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK))
              || (d_size != hit_size);
    err_vec                     = '0;
    err_vec[ERR_A_STABLE - 1]   = a_stab_err;
    err_vec[ERR_A_ILLEGAL - 1]  = a_fire && a_illegal;
    err_vec[ERR_DUP_SOURCE - 1] = a_fire && a_dup;
    err_vec[ERR_OVERFLOW - 1]   = a_fire && !a_illegal && !a_dup && tbl_full;
    err_vec[ERR_D_UNMATCH - 1]  = d_fire && !d_hit;
    err_vec[ERR_D_MISMATCH - 1] = d_fire && d_hit && d_mismatch;
    err_vec[ERR_D_STABLE - 1]   = d_stab_err;
    err_vec[ERR_TIMEOUT - 1]    = timeout_any;

    err_pulse_d  = |err_vec;
    err_code_d   = (|err_vec) ? lowest_code(err_vec) : err_code_q;
    err_sticky_d = err_sticky_q | err_vec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_hold_q     <= 1'b0;
      d_hold_q     <= 1'b0;
      a_snap_q     <= '0;
      d_snap_q     <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= '0;
    end else begin
      a_hold_q     <= a_hold_d;
      d_hold_q     <= d_hold_d;
      a_snap_q     <= a_snap_d;
      d_snap_q     <= d_snap_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tl_ul_channel_checker.sv
// Directed bench for tl_ul_channel_checker with a queue-based reference model checked every cycle.
module tb_tl_ul_channel_checker;

  localparam int TMO = 16;
  localparam int MAXF = 8;

  logic        clock, reset;
  logic        a_valid, a_ready, a_corrupt;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [9:0]  a_source;
  logic [14:0] a_address;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [9:0]  d_source;
  logic        err_pulse;
  logic [3:0]  err_code;
  logic [7:0]  err_sticky;
  logic [3:0]  inflight;

  int n_cmp = 0;
  int n_mis = 0;

  tl_ul_channel_checker #(
    .SOURCE_W(10), .ADDR_W(15), .SIZE_W(2), .BEAT_BYTES(4), .MAX_INFLIGHT(MAXF), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky), .inflight(inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int src;
    int size;
    bit expd;
    int t0;
  } ent_t;

  ent_t q[$];
  bit   m_init = 0;
  bit   e_pulse;
  int   e_code;
  bit [7:0] e_sticky;

  function automatic bit m_illegal(input int op, input int param, input int size,
                                   input int addr, input int mask, input bit corrupt);
    int bytes, lanes;
    if (!(op == 0 || op == 1 || op == 4)) return 1;
    if (param != 0) return 1;
    if (size > 2) return 1;
    bytes = 1 << size;
    if (addr % bytes != 0) return 1;
    lanes = ((1 << bytes) - 1) << (addr % 4);
    if ((op == 4 || op == 0) && mask != lanes) return 1;
    if (op == 1 && (mask & ~lanes) != 0) return 1;
    if (op == 4 && corrupt) return 1;
    return 0;
  endfunction

  initial begin : model
    bit pa_stall, pd_stall;
    logic [37:0] pa_vec;
    logic [16:0] pd_vec;
    int cyc;
    bit [7:0] errs;
    int hit, idx;
    bit dfire, dup;
    pa_stall = 0; pd_stall = 0; pa_vec = '0; pd_vec = '0; cyc = 0;
    e_pulse = 0; e_code = 0; e_sticky = 0;
    forever begin
      @(posedge clock);
      if (reset) begin
        q.delete();
        pa_stall = 0; pd_stall = 0;
        e_pulse = 0; e_code = 0; e_sticky = 0;
        m_init = 1;
      end else begin
        errs = 0;
        if (pa_stall && (!a_valid ||
            {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt} != pa_vec)) errs[0] = 1;
        if (pd_stall && (!d_valid ||
            {d_opcode, d_size, d_source, d_denied, d_corrupt} != pd_vec)) errs[6] = 1;
        dfire = d_valid && d_ready;
        hit = -1;
        for (int i = 0; i < q.size(); i++)
          if (hit < 0 && q[i].src == int'(d_source)) hit = i;
        for (int i = 0; i < q.size(); i++)
          if (cyc - q[i].t0 == TMO && !(dfire && i == hit)) errs[7] = 1;
        if (dfire) begin
          if (hit < 0) errs[4] = 1;
          else begin
            if (int'(d_opcode) != (q[hit].expd ? 1 : 0) || int'(d_size) != q[hit].size) errs[5] = 1;
            q.delete(hit);
          end
        end
        if (a_valid && a_ready) begin
          bit ill;
          ill = m_illegal(a_opcode, a_param, a_size, a_address, a_mask, a_corrupt);
          dup = 0;
          foreach (q[i]) if (q[i].src == int'(a_source)) dup = 1;
          if (ill) errs[1] = 1;
          if (dup) errs[2] = 1;
          if (!ill && !dup) begin
            if (q.size() == MAXF) errs[3] = 1;
            else q.push_back('{src: int'(a_source), size: int'(a_size), expd: (a_opcode == 4), t0: cyc});
          end
        end
        e_pulse = (errs != 0);
        idx = -1;
        for (int i = 0; i < 8; i++) if (idx < 0 && errs[i]) idx = i;
        if (idx >= 0) e_code = idx + 1;
        e_sticky = e_sticky | errs;
        pa_stall = a_valid && !a_ready;
        pa_vec   = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt};
        pd_stall = d_valid && !d_ready;
        pd_vec   = {d_opcode, d_size, d_source, d_denied, d_corrupt};
      end
      cyc++;
      #1;
      if (m_init) begin
        chk("model err_pulse", err_pulse, e_pulse);
        chk("model err_code", err_code, e_code);
        chk("model err_sticky", err_sticky, e_sticky);
        chk("model inflight", inflight, q.size());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle();
    a_valid = 0; a_ready = 1; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_corrupt = 0;
    d_valid = 0; d_ready = 1; d_opcode = 0; d_size = 0; d_source = 0; d_denied = 0; d_corrupt = 0;
  endtask

  task automatic set_a(input bit v, input bit r, input logic [2:0] op, input logic [9:0] src,
                       input logic [14:0] addr, input logic [1:0] sz, input logic [3:0] mask);
    a_valid = v; a_ready = r; a_opcode = op; a_param = 0; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_corrupt = 0;
  endtask

  task automatic set_d(input bit v, input bit r, input logic [2:0] op, input logic [9:0] src,
                       input logic [1:0] sz);
    d_valid = v; d_ready = r; d_opcode = op; d_source = src; d_size = sz;
    d_denied = 0; d_corrupt = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : driver
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("reset err_pulse", err_pulse, 0);
    chk("reset err_code", err_code, 0);
    chk("reset err_sticky", err_sticky, 0);
    chk("reset inflight", inflight, 0);

    // Get then AccessAckData
    set_a(1, 1, 3'd4, 10'd5, 15'h10, 2'd2, 4'hF); tick(); idle();
    chk("get inflight", inflight, 1);
    chk("get no err", err_pulse, 0);
    set_d(1, 1, 3'd1, 10'd5, 2'd2); tick(); idle();
    chk("ackdata inflight", inflight, 0);
    chk("ackdata no err", err_pulse, 0);

    // A stability
    do_reset();
    set_a(1, 0, 3'd4, 10'd9, 15'h10, 2'd2, 4'hF); tick();
    a_address = 15'h14; tick();
    chk("a_stab pulse", err_pulse, 1);
    chk("a_stab code", err_code, 1);
    chk("a_stab sticky", err_sticky, 8'h01);
    a_ready = 1; tick(); idle();
    chk("a_stab then fire", err_pulse, 0);
    chk("a_stab then inflight", inflight, 1);

    // A illegal variants
    do_reset();
    set_a(1, 1, 3'd0, 10'd1, 15'h2, 2'd2, 4'hF); tick(); idle();
    chk("misaligned code", err_code, 2);
    chk("misaligned inflight", inflight, 0);
    set_a(1, 1, 3'd2, 10'd1, 15'h0, 2'd2, 4'hF); tick(); idle();
    chk("bad opcode pulse", err_pulse, 1);
    set_a(1, 1, 3'd4, 10'd1, 15'h0, 2'd2, 4'hF); a_param = 3'd1; tick(); idle();
    set_a(1, 1, 3'd4, 10'd1, 15'h0, 2'd2, 4'h7); tick(); idle();
    set_a(1, 1, 3'd4, 10'd1, 15'h0, 2'd3, 4'hF); tick(); idle();
    set_a(1, 1, 3'd4, 10'd1, 15'h0, 2'd2, 4'hF); a_corrupt = 1; tick(); idle();
    chk("illegal sticky", err_sticky, 8'h02);
    set_a(1, 1, 3'd1, 10'd2, 15'h0, 2'd2, 4'h3); tick(); idle();
    chk("putpartial legal", err_pulse, 0);
    set_a(1, 1, 3'd4, 10'd3, 15'h2, 2'd1, 4'hC); tick(); idle();
    chk("get half legal", err_pulse, 0);
    chk("legal inflight", inflight, 2);

    // duplicate source
    do_reset();
    set_a(1, 1, 3'd4, 10'd3, 15'h0, 2'd2, 4'hF); tick();
    tick(); idle();
    chk("dup code", err_code, 3);
    chk("dup inflight", inflight, 1);

    // overflow on the ninth distinct source
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_a(1, 1, 3'd4, 10'(10 + i), 15'h0, 2'd2, 4'hF); tick();
    end
    idle();
    chk("overflow code", err_code, 4);
    chk("overflow inflight", inflight, 8);

    // unmatched and mismatched D
    do_reset();
    set_d(1, 1, 3'd1, 10'd7, 2'd2); tick(); idle();
    chk("unmatched code", err_code, 5);
    chk("unmatched sticky", err_sticky, 8'h10);
    set_a(1, 1, 3'd4, 10'd1, 15'h0, 2'd2, 4'hF); tick(); idle();
    set_d(1, 1, 3'd0, 10'd1, 2'd2); tick(); idle();
    chk("mismatch code", err_code, 6);
    chk("mismatch inflight", inflight, 0);
    chk("mismatch sticky", err_sticky, 8'h30);

    // same-cycle retire and reallocate of one source, then D stability
    do_reset();
    set_a(1, 1, 3'd4, 10'd6, 15'h0, 2'd2, 4'hF); tick();
    set_d(1, 1, 3'd1, 10'd6, 2'd2); tick(); idle();
    chk("retire+alloc no err", err_pulse, 0);
    chk("retire+alloc inflight", inflight, 1);
    set_d(1, 0, 3'd1, 10'd6, 2'd2); tick();
    d_size = 2'd1; tick();
    chk("d_stab code", err_code, 7);
    d_ready = 1; tick(); idle();
    tick();

    // timeout coincident with an unmatched D
    do_reset();
    set_a(1, 1, 3'd4, 10'd2, 15'h0, 2'd2, 4'hF); tick(); idle();
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("pre-timeout quiet", err_pulse, 0);
    set_d(1, 1, 3'd1, 10'd7, 2'd2); tick(); idle();
    chk("timeout pulse", err_pulse, 1);
    chk("timeout code", err_code, 5);
    chk("timeout sticky", err_sticky, 8'h90);
    tick();
    chk("timeout single", err_pulse, 0);
    chk("timeout entry live", inflight, 1);
    for (int i = 0; i < 20; i++) tick();

    // reset discards the table
    do_reset();
    set_a(1, 1, 3'd4, 10'd4, 15'h0, 2'd2, 4'hF); tick(); idle();
    do_reset();
    set_d(1, 1, 3'd1, 10'd4, 2'd2); tick(); idle();
    chk("post-reset D code", err_code, 5);
    chk("post-reset inflight", inflight, 0);
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
